// File: rtl/ext_bus_ctrl_if.sv
// rtl/ext_bus_ctrl_if.sv - CPU port and peripheral bus bundle for ext_bus_ctrl
interface ext_bus_ctrl_if #(
    parameter int NUM_CS = 5,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                     read;
    logic                     write;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        wdata;
    logic [DATA_W-1:0]        rdata;
    logic                     busy;
    logic [NUM_CS-1:0]        cs;
    logic                     dev_rd;
    logic                     dev_wr;
    logic [ADDR_W-1:0]        dev_addr;
    logic [DATA_W-1:0]        dev_wdata;
    logic [NUM_CS*DATA_W-1:0] dev_rdata;
    logic [NUM_CS-1:0]        dev_ack;
    logic                     err_clr;
    logic                     err_timeout;
    logic                     err_unmapped;

    modport slave (
        input  read, write, addr, wdata, dev_rdata, dev_ack, err_clr,
        output rdata, busy, cs, dev_rd, dev_wr, dev_addr, dev_wdata,
               err_timeout, err_unmapped
    );

    modport master (
        output read, write, addr, wdata, dev_rdata, dev_ack, err_clr,
        input  rdata, busy, cs, dev_rd, dev_wr, dev_addr, dev_wdata,
               err_timeout, err_unmapped
    );
endinterface

// File: rtl/ext_bus_ctrl.sv
// rtl/ext_bus_ctrl.sv - region-decoding external-bus controller with ack/timeout handling
module ext_bus_ctrl #(
    parameter int                         NUM_CS       = 5,
    parameter int                         DATA_W       = 16,
    parameter int                         ADDR_W       = 16,
    parameter int                         SEL_W        = 4,
    parameter logic [NUM_CS*SEL_W-1:0]    REGION_MAP   = {4'hF, 4'hE, 4'hD, 4'hC, 4'h0},
    parameter logic [NUM_CS-1:0]          ACK_MASK     = 5'b00110,
    parameter int                         TIMEOUT      = 15,
    parameter logic [DATA_W-1:0]          TIMEOUT_DATA = 16'hDEAD
) (
    input  logic          clk,
    input  logic          rst,
    ext_bus_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t            state;
    logic [NUM_CS-1:0] cs;
    logic              dev_rd;
    logic              dev_wr;
    logic [ADDR_W-1:0] dev_addr;
    logic [DATA_W-1:0] dev_wdata;
    logic [DATA_W-1:0] rdata;
    logic [7:0]        cnt;
    logic              err_timeout;
    logic              err_unmapped;

    logic [SEL_W-1:0]  sel_bits;
    logic [NUM_CS-1:0] hit;
    logic [DATA_W-1:0] rd_mux;
    logic              ack_hit;
    logic              wait_ch;

    assign sel_bits = bus.addr[ADDR_W-1 -: SEL_W];

    // Scan from the top so the lowest matching channel is the one left standing.
    always_comb begin
        hit = '0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (sel_bits == REGION_MAP[i*SEL_W +: SEL_W]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs[i]) rd_mux = rd_mux | bus.dev_rdata[i*DATA_W +: DATA_W];
        end
    end

    assign ack_hit = |(bus.dev_ack & cs);
    assign wait_ch = |(ACK_MASK & cs);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cs           <= '0;
            dev_rd       <= 1'b0;
            dev_wr       <= 1'b0;
            dev_addr     <= '0;
            dev_wdata    <= '0;
            rdata        <= '0;
            cnt          <= '0;
            err_timeout  <= 1'b0;
            err_unmapped <= 1'b0;
        end else begin
            // Clear first so a same-cycle set event below takes precedence.
            if (bus.err_clr) begin
                err_timeout  <= 1'b0;
                err_unmapped <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.read || bus.write) begin
                        dev_addr  <= bus.addr;
                        dev_wdata <= bus.wdata;
                        if (|hit) begin
                            state  <= ACCESS;
                            cs     <= hit;
                            dev_wr <= bus.write;
                            dev_rd <= ~bus.write;
                            cnt    <= '0;
                        end else begin
                            state        <= DONE;
                            err_unmapped <= 1'b1;
                            if (!bus.write) rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 8'd1;
                    if (!wait_ch || ack_hit) begin
                        state  <= DONE;
                        cs     <= '0;
                        dev_rd <= 1'b0;
                        dev_wr <= 1'b0;
                        if (dev_rd) rdata <= rd_mux;
                    end else if (cnt == LAST_CNT) begin
                        state       <= DONE;
                        cs          <= '0;
                        dev_rd      <= 1'b0;
                        dev_wr      <= 1'b0;
                        err_timeout <= 1'b1;
                        if (dev_rd) rdata <= TIMEOUT_DATA;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = (state == ACCESS) || ((state == IDLE) && (bus.read || bus.write));
    assign bus.cs           = cs;
    assign bus.dev_rd       = dev_rd;
    assign bus.dev_wr       = dev_wr;
    assign bus.dev_addr     = dev_addr;
    assign bus.dev_wdata    = dev_wdata;
    assign bus.rdata        = rdata;
    assign bus.err_timeout  = err_timeout;
    assign bus.err_unmapped = err_unmapped;
endmodule

// File: tb/tb_ext_bus_ctrl.sv
// tb/tb_ext_bus_ctrl.sv - self-checking bench for ext_bus_ctrl
module tb_ext_bus_ctrl;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ext_bus_ctrl_if #(.NUM_CS(5), .DATA_W(16), .ADDR_W(16)) bus ();

    ext_bus_ctrl #(
        .NUM_CS(5), .DATA_W(16), .ADDR_W(16), .SEL_W(4),
        .REGION_MAP({4'hF, 4'hE, 4'hD, 4'hC, 4'h0}),
        .ACK_MASK(5'b00110), .TIMEOUT(TMO), .TIMEOUT_DATA(16'hDEAD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       name;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] val;
        int          dly;
        logic [15:0] e_rdata;
        int          e_busy;
        int          e_cyc;
        logic [4:0]  e_cs;
        bit          e_to;
        bit          e_un;
    } vec_t;

    vec_t        vecs [10];
    int          total = 0;
    int          bad   = 0;
    logic [3:0]  region_v [5];
    logic [4:0]  ack_mask_v;
    logic [15:0] m_rdata;
    bit          m_to;
    bit          m_un;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: outcome derived from region map, ack mask and ack delay.
    task automatic model(input bit wr, input logic [15:0] a, input logic [15:0] val, input int dly,
                         output logic [15:0] e_rd, output int e_busy, output int e_cyc,
                         output logic [4:0] e_cs, output bit e_to, output bit e_un);
        int ch;
        ch   = -1;
        e_rd = m_rdata;
        e_to = m_to;
        e_un = m_un;
        e_cs = '0;
        for (int i = 0; i < 5; i++)
            if (ch < 0 && a[15:12] == region_v[i]) ch = i;
        if (ch < 0) begin
            e_busy = 1; e_cyc = 0; e_un = 1'b1;
            if (!wr) e_rd = 16'h0000;
        end else begin
            e_cs[ch] = 1'b1;
            if (!ack_mask_v[ch]) begin
                e_busy = 2; e_cyc = 1;
                if (!wr) e_rd = val;
            end else if (dly < TMO) begin
                e_busy = dly + 2; e_cyc = dly + 1;
                if (!wr) e_rd = val;
            end else begin
                e_busy = TMO + 1; e_cyc = TMO; e_to = 1'b1;
                if (!wr) e_rd = 16'hDEAD;
            end
        end
    endtask

    // Entered and left at posedge+1 with the controller idle.
    task automatic run_txn(input string nm, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] val, input int dly, input logic [15:0] e_rd,
                           input int e_busy, input int e_cyc, input logic [4:0] e_cs,
                           input bit e_to, input bit e_un);
        int busy_cnt, cs_cnt, csbad, viol;
        bit done;
        busy_cnt = 0; cs_cnt = 0; csbad = 0; viol = 0; done = 1'b0;
        for (int i = 0; i < 5; i++)
            bus.dev_rdata[i*16 +: 16] = e_cs[i] ? val : 16'($urandom);
        bus.dev_ack = '0;
        bus.addr    = a;
        bus.wdata   = wd;
        bus.write   = wr;
        bus.read    = wr ? 1'($urandom) : 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.cs != 0) begin
                cs_cnt++;
                if (bus.cs != e_cs) csbad++;
                if (bus.dev_wr != wr || bus.dev_rd != !wr || bus.dev_addr != a || bus.dev_wdata != wd)
                    viol++;
            end else if (bus.dev_rd || bus.dev_wr) begin
                viol++;
            end
            bus.dev_ack = 5'($urandom) & ~e_cs;
            if (bus.cs != 0 && cs_cnt == dly + 1) bus.dev_ack = bus.dev_ack | e_cs;
            if (!bus.busy) begin
                done = 1'b1;
                check({nm, "_rdata"}, 32'(bus.rdata), 32'(e_rd));
                check({nm, "_err_timeout"}, 32'(bus.err_timeout), 32'(e_to));
                check({nm, "_err_unmapped"}, 32'(bus.err_unmapped), 32'(e_un));
            end else begin
                @(posedge clk); #1;
            end
        end
        check({nm, "_completes"}, 32'(done), 32'd1);
        check({nm, "_busy_cycles"}, busy_cnt, e_busy);
        check({nm, "_cs_cycles"}, cs_cnt, e_cyc);
        check({nm, "_cs_value_errs"}, csbad, 0);
        check({nm, "_strobe_errs"}, viol, 0);
        bus.read = 1'b0; bus.write = 1'b0; bus.dev_ack = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [15:0] e_rd, a;
        int          e_busy, e_cyc, dly;
        logic [4:0]  e_cs;
        bit          e_to, e_un, wr;
        int          first_cs, second_cs, multi, dones;

        region_v   = '{4'h0, 4'hC, 4'hD, 4'hE, 4'hF};
        ack_mask_v = 5'b00110;

        vecs[0] = '{"zw_rd_ch0",     1'b0, 16'h0012, 16'h0000, 16'h1234, 0,  16'h1234, 2,  1,  5'b00001, 1'b0, 1'b0};
        vecs[1] = '{"ack_wr_ch1",    1'b1, 16'hC004, 16'hBEEF, 16'h7777, 3,  16'h1234, 5,  4,  5'b00010, 1'b0, 1'b0};
        vecs[2] = '{"tmo_rd_ch2",    1'b0, 16'hD000, 16'h0000, 16'h3333, 99, 16'hDEAD, 16, 15, 5'b00100, 1'b1, 1'b0};
        vecs[3] = '{"unmapped_rd",   1'b0, 16'h5000, 16'h0000, 16'h9999, 0,  16'h0000, 1,  0,  5'b00000, 1'b1, 1'b1};
        vecs[4] = '{"zw_rd_ch4",     1'b0, 16'hF0A0, 16'h0000, 16'h4444, 5,  16'h4444, 2,  1,  5'b10000, 1'b1, 1'b1};
        vecs[5] = '{"ack0_rd_ch1",   1'b0, 16'hC010, 16'h0000, 16'h5151, 0,  16'h5151, 2,  1,  5'b00010, 1'b1, 1'b1};
        vecs[6] = '{"zw_rd_ch3",     1'b0, 16'hE123, 16'h0000, 16'h3E3E, 7,  16'h3E3E, 2,  1,  5'b01000, 1'b1, 1'b1};
        vecs[7] = '{"ack_last_ch2",  1'b0, 16'hD0FF, 16'h0000, 16'h2222, 14, 16'h2222, 16, 15, 5'b00100, 1'b1, 1'b1};
        vecs[8] = '{"zw_wr_ch0",     1'b1, 16'h0FFE, 16'h0A0A, 16'h6666, 0,  16'h2222, 2,  1,  5'b00001, 1'b1, 1'b1};
        vecs[9] = '{"unmapped_wr",   1'b1, 16'h8000, 16'h0001, 16'h0000, 0,  16'h2222, 1,  0,  5'b00000, 1'b1, 1'b1};

        rst = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.dev_rdata = '0; bus.dev_ack = '0; bus.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cs", 32'(bus.cs), 32'd0);
        check("rst_strobes", {30'd0, bus.dev_rd, bus.dev_wr}, 32'd0);
        check("rst_dev_addr", 32'(bus.dev_addr), 32'd0);
        check("rst_dev_wdata", 32'(bus.dev_wdata), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_flags", {30'd0, bus.err_timeout, bus.err_unmapped}, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_txn(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].val, vecs[i].dly,
                    vecs[i].e_rdata, vecs[i].e_busy, vecs[i].e_cyc, vecs[i].e_cs, vecs[i].e_to, vecs[i].e_un);
        m_rdata = 16'h2222; m_to = 1'b1; m_un = 1'b1;

        // Sticky clear, then a clear coinciding with a fresh unmapped hit.
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        check("clr_flags", {30'd0, bus.err_timeout, bus.err_unmapped}, 32'd0);
        bus.read = 1'b1; bus.addr = 16'h5000; bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        check("clr_vs_set_unmapped", 32'(bus.err_unmapped), 32'd1);
        check("clr_vs_set_busy", 32'(bus.busy), 32'd0);
        check("clr_vs_set_rdata", 32'(bus.rdata), 32'd0);
        bus.read = 1'b0;
        @(posedge clk); #1;
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        check("clr_again", {30'd0, bus.err_timeout, bus.err_unmapped}, 32'd0);
        m_rdata = 16'h0000; m_to = 1'b0; m_un = 1'b0;

        for (int n = 0; n < 40; n++) begin
            int k;
            k = $urandom_range(0, 5);
            a = {(k < 5) ? region_v[k] : 4'($urandom_range(1, 11)), 12'($urandom)};
            wr = 1'($urandom);
            dly = $urandom_range(0, 20);
            begin
                logic [15:0] wd, val;
                wd = 16'($urandom); val = 16'($urandom);
                model(wr, a, val, dly, e_rd, e_busy, e_cyc, e_cs, e_to, e_un);
                run_txn($sformatf("rand%0d", n), wr, a, wd, val, dly, e_rd, e_busy, e_cyc, e_cs, e_to, e_un);
            end
            m_rdata = e_rd; m_to = e_to; m_un = e_un;
        end

        // Back-to-back zero-wait reads with the request held throughout.
        bus.dev_rdata = '0;
        bus.dev_rdata[15:0] = 16'h1111;
        bus.dev_rdata[79:64] = 16'h4444;
        bus.read = 1'b1; bus.addr = 16'h0012;
        first_cs = -1; second_cs = -1; multi = 0; dones = 0;
        for (int c = 0; c < 12 && dones < 2; c++) begin
            #1;
            if (bus.cs == 5'b00001 && first_cs < 0) first_cs = c;
            if (bus.cs == 5'b10000 && second_cs < 0) second_cs = c;
            if ($countones(bus.cs) > 1) multi++;
            if (!bus.busy) begin
                dones++;
                if (dones == 1) begin
                    check("b2b_rdata_ch0", 32'(bus.rdata), 32'h1111);
                    bus.addr = 16'hF000;
                end else begin
                    check("b2b_rdata_ch4", 32'(bus.rdata), 32'h4444);
                end
            end
            @(posedge clk); #1;
        end
        bus.read = 1'b0;
        check("b2b_dones", dones, 2);
        check("b2b_first_cs_cycle", first_cs, 1);
        check("b2b_spacing", second_cs - first_cs, 3);
        check("b2b_multi_hot", multi, 0);
        m_rdata = 16'h4444;

        // Leave nonzero state behind, then reset in the middle of an ack access.
        model(1'b0, 16'h7000, 16'h0, 0, e_rd, e_busy, e_cyc, e_cs, e_to, e_un);
        run_txn("pre_rst_unmapped", 1'b0, 16'h7000, 16'h0, 16'h0, 0, e_rd, e_busy, e_cyc, e_cs, e_to, e_un);
        m_rdata = e_rd; m_to = e_to; m_un = e_un;
        run_txn("pre_rst_rd_ch0", 1'b0, 16'h0040, 16'h0, 16'h5A5A, 0, 16'h5A5A, 2, 1, 5'b00001, m_to, m_un);
        bus.dev_ack = '0; bus.read = 1'b1; bus.addr = 16'hC000;
        @(posedge clk); #1;
        check("mid_rst_cs_before", 32'(bus.cs), 32'h2);
        @(posedge clk); #1;
        rst = 1'b1; bus.read = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_cs", 32'(bus.cs), 32'd0);
        check("mid_rst_dev_rd", 32'(bus.dev_rd), 32'd0);
        check("mid_rst_rdata", 32'(bus.rdata), 32'd0);
        check("mid_rst_flags", {30'd0, bus.err_timeout, bus.err_unmapped}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("post_rst_idle_cs", 32'(bus.cs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
